// File: rtl/qdr2_pkg.sv
// Shared constants and types for the QDR-II burst-of-4 SRAM model.
package qdr2_pkg;
   localparam int BEATS     = 4;
   localparam int BYTE_W    = 9;
   localparam int NUM_BYTES = 4;

   typedef logic [1:0] beat_t;
   typedef enum logic [0:0] {IDLE = 1'b0, BURST = 1'b1} eng_state_e;

   localparam beat_t LAST_BEAT = beat_t'(BEATS - 1);
endpackage

// File: rtl/qdr2_burst_engine.sv
// Burst sequencer shared by the read and write paths: latches the burst address
// and walks the beat index; free in idle or in the final beat so bursts chain gap-free.
module qdr2_burst_engine
   import qdr2_pkg::*;
#(
   parameter int AW = 10
) (
   input  logic          CLK,
   input  logic          RESET,
   input  logic          i_start,
   input  logic [AW-1:0] i_addr,
   output logic          o_free,
   output logic          o_active,
   output beat_t         o_beat,
   output logic [AW-1:0] o_addr
);
   eng_state_e    r_state;
   beat_t         r_beat;
   logic [AW-1:0] r_addr;

   assign o_free   = (r_state == IDLE) || (r_beat == LAST_BEAT);
   assign o_active = (r_state == BURST);
   assign o_beat   = r_beat;
   assign o_addr   = r_addr;

   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_state <= IDLE;
         r_beat  <= '0;
      end else if (i_start) begin
         r_state <= BURST;
         r_beat  <= '0;
      end else if (r_state == BURST) begin
         if (r_beat == LAST_BEAT) begin
            r_state <= IDLE;
         end
         r_beat <= r_beat + beat_t'(1);
      end
   end

   always_ff @(posedge CLK) begin
      if (i_start) begin
         r_addr <= i_addr;
      end
   end
endmodule

// File: rtl/qdr2_b4_sram_model.sv
// Cycle-accurate QDR-II burst-of-4 x36 SRAM model with independent read/write engines.
// Build option: define QDR_BYTE_WRITE_EN to honour BWSb byte-write enables.
module qdr2_b4_sram_model
   import qdr2_pkg::*;
#(
   parameter int ADDR_W     = 19,
   parameter int MEM_ADDR_W = 10,
   parameter int DATA_W     = 36,
   parameter int RL         = 2
) (
   input  logic                 CLK,
   input  logic                 RESET,
   input  logic [ADDR_W-1:0]    A,
   input  logic                 RPSb,
   input  logic                 WPSb,
   input  logic [DATA_W-1:0]    D,
   input  logic [NUM_BYTES-1:0] BWSb,
   output logic [DATA_W-1:0]    Q,
   output logic                 Q_VALID
);
   localparam int WORD_AW = MEM_ADDR_W + 2;
   localparam int DEPTH   = 1 << WORD_AW;
   localparam int DLY     = (RL > 2) ? (RL - 2) : 0;

   logic                  w_rd_free, w_wr_free;
   logic                  w_rd_start, w_wr_start;
   logic                  w_rd_active, w_wr_active;
   beat_t                 w_rd_beat, w_wr_beat;
   logic [MEM_ADDR_W-1:0] w_rd_addr, w_wr_addr;
   logic [WORD_AW-1:0]    w_rd_word, w_wr_word;
   logic [NUM_BYTES-1:0]  w_byte_we;
   logic [DATA_W-1:0]     w_rd_lanes;
   logic                  w_stage_v;
   logic [DLY:0]          w_chain_v;
   logic [DATA_W-1:0]     w_chain_d [DLY+1];
   logic                  w_unused_bits;

   // A simultaneous read wins; the write is only dropped when the read is actually taken.
   assign w_rd_start = !RESET && !RPSb && w_rd_free;
   assign w_wr_start = !RESET && !WPSb && w_wr_free && !w_rd_start;

   qdr2_burst_engine #(.AW(MEM_ADDR_W)) u_rd_engine (
      .CLK      (CLK),
      .RESET    (RESET),
      .i_start  (w_rd_start),
      .i_addr   (A[MEM_ADDR_W-1:0]),
      .o_free   (w_rd_free),
      .o_active (w_rd_active),
      .o_beat   (w_rd_beat),
      .o_addr   (w_rd_addr)
   );

   qdr2_burst_engine #(.AW(MEM_ADDR_W)) u_wr_engine (
      .CLK      (CLK),
      .RESET    (RESET),
      .i_start  (w_wr_start),
      .i_addr   (A[MEM_ADDR_W-1:0]),
      .o_free   (w_wr_free),
      .o_active (w_wr_active),
      .o_beat   (w_wr_beat),
      .o_addr   (w_wr_addr)
   );

   assign w_rd_word = {w_rd_addr, w_rd_beat};
   assign w_wr_word = {w_wr_addr, w_wr_beat};

`ifdef QDR_BYTE_WRITE_EN
   assign w_byte_we     = {NUM_BYTES{w_wr_active && !RESET}} & ~BWSb;
   assign w_unused_bits = ^A[ADDR_W-1:MEM_ADDR_W];
`else
   assign w_byte_we     = {NUM_BYTES{w_wr_active && !RESET}};
   assign w_unused_bits = ^{A[ADDR_W-1:MEM_ADDR_W], BWSb};
`endif

   genvar gi;

   // One array per byte lane; the read samples the array before this edge's write.
   for (gi = 0; gi < NUM_BYTES; gi++) begin : g_lane
      logic [BYTE_W-1:0] r_mem [DEPTH];

      always_ff @(posedge CLK) begin
         if (w_byte_we[gi]) begin
            r_mem[w_wr_word] <= D[gi*BYTE_W +: BYTE_W];
         end
      end

      if (RL == 1) begin : g_async
         assign w_rd_lanes[gi*BYTE_W +: BYTE_W] = r_mem[w_rd_word];
      end else begin : g_sync
         logic [BYTE_W-1:0] r_rd;
         always_ff @(posedge CLK) begin
            r_rd <= r_mem[w_rd_word];
         end
         assign w_rd_lanes[gi*BYTE_W +: BYTE_W] = r_rd;
      end
   end

   if (RL == 1) begin : g_v_async
      assign w_stage_v = w_rd_active;
   end else begin : g_v_sync
      logic r_rd_v;
      always_ff @(posedge CLK) begin
         if (RESET) begin
            r_rd_v <= 1'b0;
         end else begin
            r_rd_v <= w_rd_active;
         end
      end
      assign w_stage_v = r_rd_v;
   end

   assign w_chain_v[0] = w_stage_v;
   assign w_chain_d[0] = w_rd_lanes;

   // Extra latency stages for RL above the native array read latency.
   for (gi = 0; gi < DLY; gi++) begin : g_dly
      logic              r_v;
      logic [DATA_W-1:0] r_d;
      always_ff @(posedge CLK) begin
         if (RESET) begin
            r_v <= 1'b0;
         end else begin
            r_v <= w_chain_v[gi];
         end
         r_d <= w_chain_d[gi];
      end
      assign w_chain_v[gi+1] = r_v;
      assign w_chain_d[gi+1] = r_d;
   end

   assign Q_VALID = w_chain_v[DLY];
   assign Q       = w_chain_v[DLY] ? w_chain_d[DLY] : '0;
endmodule

// File: tb/tb_qdr2_b4_sram_model.sv
// Scoreboard bench for qdr2_b4_sram_model: directed test-plan bursts then random traffic.
module tb_qdr2_b4_sram_model;
   localparam int ADDR_W     = 19;
   localparam int MEM_ADDR_W = 10;
   localparam int DATA_W     = 36;
   localparam int RL         = 2;

   logic              CLK = 1'b0;
   logic              RESET = 1'b1;
   logic [ADDR_W-1:0] A = '0;
   logic              RPSb = 1'b1;
   logic              WPSb = 1'b1;
   logic [DATA_W-1:0] D = '0;
   logic [3:0]        BWSb = 4'hF;
   logic [DATA_W-1:0] Q;
   logic              Q_VALID;

   qdr2_b4_sram_model #(
      .ADDR_W(ADDR_W), .MEM_ADDR_W(MEM_ADDR_W), .DATA_W(DATA_W), .RL(RL)
   ) dut (
      .CLK(CLK), .RESET(RESET), .A(A), .RPSb(RPSb), .WPSb(WPSb),
      .D(D), .BWSb(BWSb), .Q(Q), .Q_VALID(Q_VALID)
   );

   always #5 CLK = ~CLK;

   typedef struct {int cyc; int word; int qcyc;} rd_beat_t;
   typedef struct {int cyc; int word; logic [35:0] d; logic [3:0] be;} wr_beat_t;
   typedef struct {int qcyc; logic [35:0] d;} exp_t;

   rd_beat_t    rd_q[$];
   wr_beat_t    wr_q[$];
   exp_t        exp_q[$];
   logic [35:0] ref_mem [int];
   logic [35:0] stg_d [4];
   logic [3:0]  stg_be [4];

   int cyc_cnt = 0;
   int errors  = 0;
   int checks  = 0;
   int rd_next = 0;
   int wr_next = 0;
   bit mon_en  = 1'b0;

   always @(posedge CLK) cyc_cnt <= cyc_cnt + 1;

   // One bus cycle: drive request, update the reference model for that cycle.
   task automatic step(input bit rst, input bit rps_n, input bit wps_n, input logic [ADDR_W-1:0] a);
      int       n;
      int       base;
      bit       rd_acc;
      bit       wr_acc;
      rd_beat_t r;
      wr_beat_t w;
      exp_t     e;
      @(posedge CLK);
      #1;
      n     = cyc_cnt;
      RESET = rst;
      RPSb  = rps_n;
      WPSb  = wps_n;
      A     = a;
      base  = int'(a[MEM_ADDR_W-1:0]) * 4;
      rd_acc = !rst && !rps_n && (n >= rd_next);
      wr_acc = !rst && !wps_n && (n >= wr_next) && !rd_acc;
      if (rd_acc) begin
         rd_next = n + 4;
         for (int k = 0; k < 4; k++) begin
            r.cyc = n + 1 + k; r.word = base + k; r.qcyc = n + RL + k;
            rd_q.push_back(r);
         end
      end
      if (wr_acc) begin
         wr_next = n + 4;
         for (int k = 0; k < 4; k++) begin
            w.cyc = n + 1 + k; w.word = base + k; w.d = stg_d[k]; w.be = stg_be[k];
            wr_q.push_back(w);
         end
      end
      D    = {4'($urandom), 32'($urandom)};
      BWSb = 4'($urandom);
      while (rd_q.size() > 0 && rd_q[0].cyc == n) begin
         r = rd_q.pop_front();
         e.qcyc = r.qcyc;
         e.d    = ref_mem[r.word];
         exp_q.push_back(e);
      end
      if (wr_q.size() > 0 && wr_q[0].cyc == n) begin
         w = wr_q.pop_front();
         D    = w.d;
         BWSb = w.be;
         if (!rst) begin
`ifdef QDR_BYTE_WRITE_EN
            for (int b = 0; b < 4; b++)
               if (!w.be[b]) ref_mem[w.word][9*b +: 9] = w.d[9*b +: 9];
`else
            ref_mem[w.word] = w.d;
`endif
         end
      end
      if (rst) begin
         rd_q.delete();
         wr_q.delete();
         while (exp_q.size() > 0 && exp_q[exp_q.size()-1].qcyc > n) void'(exp_q.pop_back());
         rd_next = n + 1;
         wr_next = n + 1;
      end
   endtask

   task automatic idle(input int cycles);
      for (int i = 0; i < cycles; i++) step(1'b0, 1'b1, 1'b1, '0);
   endtask

   task automatic set_burst(input logic [35:0] d0, input logic [35:0] d1,
                            input logic [35:0] d2, input logic [35:0] d3, input logic [3:0] be0);
      stg_d[0] = d0; stg_d[1] = d1; stg_d[2] = d2; stg_d[3] = d3;
      stg_be[0] = be0; stg_be[1] = 4'hF; stg_be[2] = 4'hF; stg_be[3] = 4'hF;
      if (be0 == 4'h0) begin
         stg_be[1] = 4'h0; stg_be[2] = 4'h0; stg_be[3] = 4'h0;
      end
   endtask

   task automatic rand_burst();
      for (int k = 0; k < 4; k++) begin
         stg_d[k]  = {4'($urandom), 32'($urandom)};
         stg_be[k] = 4'($urandom);
      end
   endtask

   // Monitor: checks every cycle's Q/Q_VALID against the expected-beat queue.
   initial begin : monitor
      exp_t e;
      int   n;
      forever begin
         @(negedge CLK);
         if (mon_en) begin
            n = cyc_cnt;
            while (exp_q.size() > 0 && exp_q[0].qcyc < n) begin
               e = exp_q.pop_front();
               checks++; errors++;
               $display("FAIL missing_beat: cycle %0d got Q_VALID=0, required data %h", e.qcyc, e.d);
            end
            checks++;
            if (Q_VALID) begin
               if (exp_q.size() == 0 || exp_q[0].qcyc != n) begin
                  errors++;
                  $display("FAIL spurious_beat: cycle %0d got Q_VALID=1 Q=%h, required Q_VALID=0", n, Q);
               end else begin
                  e = exp_q.pop_front();
                  if (Q !== e.d) begin
                     errors++;
                     $display("FAIL q_data: cycle %0d got Q=%h, required %h", n, Q, e.d);
                  end else begin
                     $display("read beat cycle %0d Q=%h ok", n, Q);
                  end
               end
            end else if (Q !== '0) begin
               errors++;
               $display("FAIL idle_q: cycle %0d got Q=%h with Q_VALID=0, required 0", n, Q);
            end
         end
      end
   end

   initial begin : stimulus
      for (int k = 0; k < 4; k++) begin
         stg_d[k] = '0; stg_be[k] = 4'h0;
      end
      step(1'b1, 1'b1, 1'b1, '0);
      step(1'b1, 1'b1, 1'b1, '0);
      mon_en = 1'b1;
      idle(2);

      // Prefill burst addresses 0..15 so every later read has known contents.
      for (int a = 0; a < 16; a++) begin
         rand_burst();
         for (int k = 0; k < 4; k++) stg_be[k] = 4'h0;
         step(1'b0, 1'b1, 1'b0, ADDR_W'(a));
         idle(3);
      end
      idle(2);

      // Full write then read of 0x005.
      set_burst(36'h111111111, 36'h222222222, 36'h333333333, 36'h444444444, 4'h0);
      step(1'b0, 1'b1, 1'b0, 19'h00005);
      idle(3);
      step(1'b0, 1'b0, 1'b1, 19'h00005);
      idle(5);

      // Back-to-back reads four cycles apart, then a read that arrives while busy.
      step(1'b0, 1'b0, 1'b1, 19'h00005);
      idle(3);
      step(1'b0, 1'b0, 1'b1, 19'h00006);
      step(1'b0, 1'b0, 1'b1, 19'h00007);
      idle(6);

      // Partial write of beat 0; other beats rewritten with their current contents.
      set_burst(36'h1FF1FF1FF, ref_mem[21], ref_mem[22], ref_mem[23], 4'b1110);
      step(1'b0, 1'b1, 1'b0, 19'h00005);
      idle(3);
      step(1'b0, 1'b0, 1'b1, 19'h00005);
      idle(5);

      // Simultaneous read and write: read wins and the write is dropped.
      set_burst(36'hABCABCABC, 36'h0DEADBEEF, 36'h123456789, 36'h987654321, 4'h0);
      step(1'b0, 1'b0, 1'b0, 19'h00007);
      idle(5);
      step(1'b0, 1'b0, 1'b1, 19'h00007);
      idle(5);

      // Aliasing of upper address bits.
      set_burst(36'h0A0A0A0A0, 36'h0B0B0B0B0, 36'h0C0C0C0C0, 36'h0D0D0D0D0, 4'h0);
      step(1'b0, 1'b1, 1'b0, 19'h00405);
      idle(3);
      step(1'b0, 1'b0, 1'b1, 19'h00005);
      idle(5);

      // Reset in the middle of a read burst, then a fresh read.
      step(1'b0, 1'b0, 1'b1, 19'h00005);
      idle(2);
      step(1'b1, 1'b0, 1'b0, 19'h00006);
      idle(2);
      step(1'b0, 1'b0, 1'b1, 19'h00006);
      idle(6);

      // Random traffic with occasional reset.
      for (int i = 0; i < 400; i++) begin
         logic [ADDR_W-1:0] ra;
         ra = {9'($urandom), 6'b0, 4'($urandom_range(0, 15))};
         rand_burst();
         step($urandom_range(0, 99) == 0, $urandom_range(0, 2) != 0,
              $urandom_range(0, 2) != 0, ra);
      end
      idle(10);

      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expected beats never seen, required 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/qdr2_b4_sram_model.md
Name: qdr2_b4_sram_model

Overview:
- Single-clock, cycle-accurate model of a QDR-II burst-of-4 x36 SRAM.
- Replaces the external QDR device behind the QDR controller in system simulation.
- Independent read and write pipelines share one address bus; each request moves 4 consecutive 36-bit beats, one beat per CLK cycle.
- Array depth is parameterised so the model stays small; upper address bits alias.

Parameters:
- ADDR_W, 19, width of burst address port A.
- MEM_ADDR_W, 10, modelled burst-address bits; array holds 2^MEM_ADDR_W x 4 words.
- DATA_W, 36, beat width; fixed as 4 bytes of 9 bits.
- RL, 2, cycles from accepted read request to first Q beat; legal range 1..4.

Ports:
- CLK  in  1  sole clock; all activity on rising edge.
- RESET  in  1  synchronous, active-high reset.
- A  in  ADDR_W  burst address; sampled with RPSb or WPSb.
- RPSb  in  1  active-low read request.
- WPSb  in  1  active-low write request.
- D  in  36  write data beat.
- BWSb  in  4  active-low byte-write enables; bit i covers D[9i+8:9i].
- Q  out  36  read data beat.
- Q_VALID  out  1  high on each cycle Q carries a valid beat.

Behaviour:
- Word address = {A[MEM_ADDR_W-1:0], beat[1:0]}; beats 0..3 in order. A[ADDR_W-1:MEM_ADDR_W] ignored.
- Array has no reset; contents are X until written.

Reads:
- RPSb low at cycle t, read engine free: request accepted.
- Q beat k (k=0..3) driven at cycle t+RL+k with Q_VALID=1.
- Read engine is free when idle or in its final beat-issue cycle, so requests every 4th cycle give gap-free Q.
- RPSb low while the engine is busy (not final cycle) is ignored.

Writes:
- WPSb low at t, write engine free: request accepted.
- D/BWSb beat k sampled at t+1+k and committed at that edge.
- Same free/back-to-back rule as reads, with a 4-cycle write period.

Collisions and hazards:
- RPSb and WPSb both low in the same cycle with both engines free: read accepted, write dropped.
- If the read engine is busy, the write is accepted.
- Same word read and written in the same cycle: Q returns the pre-write value (read-before-write).
- Writes committed in earlier cycles are visible.

Outputs and reset:
- Q = 0 and Q_VALID = 0 whenever no valid beat.
- RESET: both engines go idle next edge; Q = 0, Q_VALID = 0; pending beats discarded.
- Write beats already committed before reset remain in the array.
- Requests presented during RESET are ignored.

Optional Feature:
- Macro QDR_BYTE_WRITE_EN.
- Defined: only bytes with BWSb[i]=0 are written; others keep their old value.
- Undefined: BWSb ignored; every write beat writes all 36 bits.

Decomposition:
- Package qdr2_pkg: BEATS=4, BYTE_W=9, NUM_BYTES=4, beat-index type, engine state enum (IDLE, BURST).
- One sub-module, qdr2_burst_engine, instantiated twice (read, write): tracks the active flag, beat counter and latched address, and emits the free signal.

Test Plan:
- Write A=0x005, D=0x111111111/0x222222222/0x333333333/0x444444444, BWSb=0; then read A=0x005 -> Q_VALID at t+2..t+5 with those 4 words in order.
- Back-to-back reads at A=0x005 and 0x006 four cycles apart -> 8 contiguous Q_VALID beats, no gap.
- Partial write, QDR_BYTE_WRITE_EN defined: overwrite beat 0 of 0x005 with 0x1FF1FF1FF, BWSb=4'b1110 -> read returns 0x1111111FF. Macro undefined -> 0x1FF1FF1FF.
- RPSb and WPSb low together at A=0x007 -> read burst returns prior contents; no write occurs.
- Alias check, MEM_ADDR_W=10: write A=0x00405, read A=0x00005 -> same data.
- RESET asserted mid read burst after beat 1 -> Q_VALID=0, Q=0 from next cycle; a new read after reset completes normally.
